hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, mult/multu busy cycles after start.
REQ-002 SHALL have parameter DIV_CYC, default 10, div/divu busy cycles after start.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 D_rs  in  5  rs register index of instr in D.
REQ-006 D_rt  in  5  rt register index of instr in D.
REQ-007 D_rs_tuse  in  2  cycles until D instr needs rs; 3 = unused.
REQ-008 D_rt_tuse  in  2  cycles until D instr needs rt; 3 = unused.
REQ-009 E_dst  in  5  destination register of instr in E; 0 = none.
REQ-010 E_tnew  in  2  cycles until E result is forwardable.
REQ-011 M_dst  in  5  destination register of instr in M; 0 = none.
REQ-012 M_tnew  in  2  cycles until M result is forwardable.
REQ-013 D_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-014 E_start  in  1  one-cycle pulse, mult/div in E issues to MDU.
REQ-015 E_is_div  in  1  qualifies E_start: 1 = div class, 0 = mult class.
REQ-016 PC_en  out  1  PC register write enable.
REQ-017 FD_en  out  1  F/D pipeline register enable.
REQ-018 DE_clr  out  1  D/E pipeline register clear (bubble insert).
REQ-019 md_busy  out  1  MDU occupied.
REQ-020 md_done  out  1  one-cycle pulse in final busy cycle.
REQ-021 stall_cnt  out  32  saturating count of stalled cycles.

Function
REQ-022 SHALL compute rs_hz = (D_rs!=0) & ((D_rs==E_dst & D_rs_tuse<E_tnew) | (D_rs==M_dst & D_rs_tuse<M_tnew)); rt_hz likewise with D_rt/D_rt_tuse.
REQ-023 SHALL compute md_hz = D_is_md & md_busy.
REQ-024 SHALL assert stall = rs_hz | rt_hz | md_hz, combinationally in the same cycle.
REQ-025 SHALL drive PC_en = ~stall, FD_en = ~stall, DE_clr = stall.
REQ-026 SHALL implement MDU FSM with states IDLE and BUSY and a 4-bit down-counter cnt.
REQ-027 In IDLE with E_start=1, SHALL load cnt = DIV_CYC if E_is_div, else MULT_CYC, and enter BUSY next cycle.
REQ-028 In BUSY, SHALL decrement cnt each cycle and return to IDLE on the cycle after cnt==1.
REQ-029 SHALL drive md_busy = E_start | (state==BUSY); the start cycle counts as busy.
REQ-030 SHALL pulse md_done for exactly one cycle, when state==BUSY and cnt==1.
REQ-031 SHALL ignore E_start while in BUSY; state and cnt are unaffected.
REQ-032 SHALL increment stall_cnt on every cycle with stall=1, holding at 0xFFFFFFFF (no wrap).
REQ-033 Outputs other than stall_cnt, md_busy and md_done SHALL depend only on current inputs and state, with no extra latency.

Reset
REQ-034 On reset, SHALL set state=IDLE, cnt=0 and stall_cnt=0; md_busy and md_done read 0 unless E_start is high.
REQ-035 Reset SHALL override E_start in the same cycle and abort any in-flight BUSY immediately.

Structure
REQ-036 Shared package SHALL hold FSM state encoding, TUSE_NONE=3, MULT_CYC/DIV_CYC defaults.
REQ-037 The MDU busy FSM and counter SHALL be a sub-module md_timer; hazard compare logic stays in hazard_ctrl.

Verification
REQ-038 D_rs=8, D_rs_tuse=0, E_dst=8, E_tnew=2 -> stall=1, PC_en=0, FD_en=0, DE_clr=1.
REQ-039 D_rs=0, E_dst=0, E_tnew=2, D_rs_tuse=0 -> stall=0 (register $0 never hazards).
REQ-040 E_start=1, E_is_div=0 at cycle t -> md_busy=1 for cycles t..t+5, md_done=1 only at t+5, md_busy=0 at t+6.
REQ-041 Div start at t, D_is_md=1 held -> stall=1 for cycles t..t+10, stall=0 at t+11; stall_cnt advances by 11.
REQ-042 Div start, reset asserted at t+4 -> md_busy=0 and stall_cnt=0 at t+5; E_start during BUSY ignored, md_done still at original t+10 when no reset is applied.
REQ-043 stall_cnt preset near max via forced stalls -> reaches 0xFFFFFFFF and holds under continued stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: MDU timer state encoding,
// the "operand unused" tuse code, default MDU latencies and the operand hazard test.
package hazard_ctrl_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [1:0] TUSE_NONE    = 2'd3;
    localparam int         MULT_CYC_DEF = 5;
    localparam int         DIV_CYC_DEF  = 10;

    // A source operand hazards when a younger-needed value is still in flight in E or M.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (src == e_dst) && (tuse < e_tnew);
        m_hit = (src == m_dst) && (tuse < m_tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// MDU occupancy timer: tracks a started mult/div through its fixed latency
// and flags the final busy cycle.
module md_timer #(
    parameter int MULT_CYC = hazard_ctrl_pkg::MULT_CYC_DEF,
    parameter int DIV_CYC  = hazard_ctrl_pkg::DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic E_start,
    input  logic E_is_div,
    output logic md_busy,
    output logic md_done
);
    import hazard_ctrl_pkg::*;

    md_state_e  state_q;
    logic [3:0] cnt_q;
    logic       busy_s;

    // Busy FSM with its down-counter; starts arriving while busy are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (E_start) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= E_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
                    end else begin
                        state_q <= MD_IDLE;
                        cnt_q   <= cnt_q;
                    end
                end
                MD_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= MD_IDLE;
                    end else begin
                        state_q <= MD_BUSY;
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Reset masks a stale BUSY in its own cycle so an abort takes effect at once.
    assign busy_s  = (state_q == MD_BUSY) && !reset;
    assign md_busy = E_start || busy_s;
    assign md_done = busy_s && (cnt_q == 4'd1);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand RAW stalls against E/M, MDU-busy stalls,
// pipeline enable/clear generation and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MULT_CYC = hazard_ctrl_pkg::MULT_CYC_DEF,
    parameter int DIV_CYC  = hazard_ctrl_pkg::DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic [4:0]  E_dst,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_dst,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);
    import hazard_ctrl_pkg::*;

    logic        rs_hz_s;
    logic        rt_hz_s;
    logic        md_hz_s;
    logic        stall_s;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    md_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_is_div (E_is_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    assign rs_hz_s = src_hazard(D_rs, D_rs_tuse, E_dst, E_tnew, M_dst, M_tnew);
    assign rt_hz_s = src_hazard(D_rt, D_rt_tuse, E_dst, E_tnew, M_dst, M_tnew);
    assign md_hz_s = D_is_md && md_busy;
    assign stall_s = rs_hz_s || rt_hz_s || md_hz_s;

    assign PC_en  = !stall_s;
    assign FD_en  = !stall_s;
    assign DE_clr = stall_s;

    // Next stall count: saturate at all-ones rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// compared each cycle against a time-window reference model.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_dst, M_dst;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, E_start, E_is_div;
    logic        PC_en, FD_en, DE_clr, md_busy, md_done;
    logic [31:0] stall_cnt;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    longint b_start = -1;
    longint b_end = -1;
    longint m_cnt = 0;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rs_tuse (D_rs_tuse),
        .D_rt_tuse (D_rt_tuse),
        .E_dst     (E_dst),
        .E_tnew    (E_tnew),
        .M_dst     (M_dst),
        .M_tnew    (M_tnew),
        .D_is_md   (D_is_md),
        .E_start   (E_start),
        .E_is_div  (E_is_div),
        .PC_en     (PC_en),
        .FD_en     (FD_en),
        .DE_clr    (DE_clr),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit op_hz(input int src, input int tuse);
        return src != 0 && ((src == E_dst && tuse < E_tnew) || (src == M_dst && tuse < M_tnew));
    endfunction

    task automatic quiet();
        D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        E_dst = 5'd0; E_tnew = 2'd0; M_dst = 5'd0; M_tnew = 2'd0;
        D_is_md = 1'b0; E_start = 1'b0; E_is_div = 1'b0; reset = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one cycle.
    task automatic cycle();
        bit in_busy, e_busy, e_done, e_stall;
        #1;
        in_busy = (cyc > b_start) && (cyc <= b_end);
        e_busy  = E_start || (!reset && in_busy);
        e_done  = !reset && in_busy && (cyc == b_end);
        e_stall = op_hz(D_rs, D_rs_tuse) || op_hz(D_rt, D_rt_tuse) || (D_is_md && e_busy);
        chk("PC_en",     {31'd0, PC_en},   {31'd0, !e_stall});
        chk("FD_en",     {31'd0, FD_en},   {31'd0, !e_stall});
        chk("DE_clr",    {31'd0, DE_clr},  {31'd0, e_stall});
        chk("md_busy",   {31'd0, md_busy}, {31'd0, e_busy});
        chk("md_done",   {31'd0, md_done}, {31'd0, e_done});
        chk("stall_cnt", stall_cnt,        m_cnt[31:0]);
        if (reset) begin
            m_cnt = 0; b_start = cyc; b_end = cyc;
        end else begin
            if (e_stall && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (E_start && !in_busy) begin
                b_start = cyc;
                b_end   = cyc + (E_is_div ? DIV_N : MULT_N);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Reset state, with a start request masked by reset.
        E_start = 1'b1;
        cycle();
        quiet();
        cycle();

        // Load-use on rs against E.
        D_rs = 5'd8; D_rs_tuse = 2'd0; E_dst = 5'd8; E_tnew = 2'd2;
        cycle();
        // Register $0 never hazards.
        D_rs = 5'd0; E_dst = 5'd0;
        cycle();
        // rt against M, then tuse equal to tnew (no stall), then unused operand.
        quiet(); D_rt = 5'd3; D_rt_tuse = 2'd1; M_dst = 5'd3; M_tnew = 2'd2;
        cycle();
        D_rt_tuse = 2'd2;
        cycle();
        D_rt_tuse = 2'd3; M_tnew = 2'd3;
        cycle();

        // Mult latency.
        quiet(); E_start = 1'b1;
        cycle();
        E_start = 1'b0;
        for (int i = 0; i < 7; i++) cycle();

        // Div with MDU-dependent instruction held in D.
        quiet(); D_is_md = 1'b1; E_start = 1'b1; E_is_div = 1'b1;
        cycle();
        E_start = 1'b0;
        for (int i = 0; i < 12; i++) cycle();

        // Div aborted by reset at t+4.
        quiet(); E_start = 1'b1; E_is_div = 1'b1; D_is_md = 1'b1;
        cycle();
        E_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Starts during BUSY are ignored.
        quiet(); E_start = 1'b1; E_is_div = 1'b1;
        cycle();
        for (int i = 0; i < 12; i++) begin
            E_start  = (i == 2 || i == 6);
            E_is_div = 1'b0;
            cycle();
        end

        // Saturation of the stall counter.
        quiet();
        force dut.stall_cnt_q = 32'hFFFF_FFFC;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 64'hFFFF_FFFC;
        D_rs = 5'd5; D_rs_tuse = 2'd0; E_dst = 5'd5; E_tnew = 2'd1;
        for (int i = 0; i < 7; i++) cycle();
        quiet(); reset = 1'b1;
        cycle();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            D_rs      = 5'($urandom_range(0, 3));
            D_rt      = 5'($urandom_range(0, 3));
            D_rs_tuse = 2'($urandom_range(0, 3));
            D_rt_tuse = 2'($urandom_range(0, 3));
            E_dst     = 5'($urandom_range(0, 3));
            M_dst     = 5'($urandom_range(0, 3));
            E_tnew    = 2'($urandom_range(0, 3));
            M_tnew    = 2'($urandom_range(0, 3));
            D_is_md   = 1'($urandom_range(0, 1));
            E_start   = ($urandom_range(0, 4) == 0);
            E_is_div  = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
